// File: rtl/ariane_pkg.sv
// Shared core types for the writeback arbiter: scoreboard ID width, exception
// record, writeback source count and source-index enum.
package ariane_pkg;

  localparam int unsigned TRANS_ID_BITS = 3;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  localparam int unsigned WbArbNrSrc = 4;

  typedef enum logic [1:0] {
    WB_SRC_FLU   = 2'd0,
    WB_SRC_LOAD  = 2'd1,
    WB_SRC_STORE = 2'd2,
    WB_SRC_FPU   = 2'd3
  } wb_src_e;

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin pick: first valid requester at or after ptr_i,
// searching upward modulo N. One-hot and index forms of the same grant.
module rr_arbiter_core #(
  parameter  int unsigned N    = 4,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    valid_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_oh_o,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            gnt_vld_o
);

  function automatic logic [IdxW-1:0] wrap(input int unsigned v);
    return IdxW'(v % N);
  endfunction

  // Scan from the farthest offset down so the nearest valid one wins last.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (valid_i[wrap(int'(ptr_i) + k)]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = wrap(int'(ptr_i) + k);
      end
    end
    gnt_oh_o = '0;
    if (gnt_vld_o) gnt_oh_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one registered writeback port among NrSrc units.
// Optional saturating conflict counter: define WB_ARB_CONFLICT_CNT_EN.
module wb_arbiter
  import ariane_pkg::*;
#(
  parameter int unsigned NrSrc = WbArbNrSrc
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic [NrSrc-1:0]                     src_valid_i,
  output logic [NrSrc-1:0]                     src_ready_o,
  input  logic [NrSrc-1:0][63:0]               src_result_i,
  input  logic [NrSrc-1:0][TRANS_ID_BITS-1:0]  src_trans_id_i,
  input  exception_t [NrSrc-1:0]               src_ex_i,
  output logic                                 wb_valid_o,
  output logic [63:0]                          wb_result_o,
  output logic [TRANS_ID_BITS-1:0]             wb_trans_id_o,
  output exception_t                           wb_ex_o,
  input  logic                                 wb_ready_i,
  output logic [31:0]                          conflict_cnt_o
);

  localparam int unsigned IdxW = $clog2(NrSrc);

  logic [NrSrc-1:0]         gnt_oh;
  logic [IdxW-1:0]          gnt_idx;
  logic                     gnt_vld;
  logic                     slot_free, xfer;

  logic [IdxW-1:0]          rr_ptr_q, rr_ptr_d;
  logic                     valid_q, valid_d;
  logic [63:0]              result_q, result_d;
  logic [TRANS_ID_BITS-1:0] id_q, id_d;
  exception_t               ex_q, ex_d;

  rr_arbiter_core #(.N(NrSrc)) i_rr_core (
    .valid_i   (src_valid_i),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  assign slot_free   = ~valid_q | wb_ready_i;
  // Reset gating keeps ready low while rst_i is held, even before the flops settle.
  assign xfer        = gnt_vld & slot_free & ~flush_i & ~rst_i;
  assign src_ready_o = xfer ? gnt_oh : '0;

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    id_d     = id_q;
    ex_d     = ex_q;
    rr_ptr_d = rr_ptr_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (xfer) begin
      valid_d  = 1'b1;
      result_d = src_result_i[gnt_idx];
      id_d     = src_trans_id_i[gnt_idx];
      ex_d     = src_ex_i[gnt_idx];
      rr_ptr_d = (gnt_idx == IdxW'(NrSrc - 1)) ? '0 : IdxW'(gnt_idx + 1'b1);
    end else if (wb_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      id_q     <= '0;
      ex_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      id_q     <= id_d;
      ex_q     <= ex_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign wb_valid_o    = valid_q;
  assign wb_result_o   = result_q;
  assign wb_trans_id_o = id_q;
  assign wb_ex_o       = ex_q;

`ifdef WB_ARB_CONFLICT_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        conflict;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign conflict = |(src_valid_i & (src_valid_i - NrSrc'(1)));
  assign cnt_d    = (conflict && (cnt_q != '1)) ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign conflict_cnt_o = cnt_q;
`else
  assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized
// traffic against a cycle-level behavioural model of the writeback port.
module tb_wb_arbiter;
  import ariane_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic wb_ready = 1'b0;
  logic [N-1:0] src_valid = '0;
  logic [N-1:0] src_ready;
  logic [N-1:0][63:0] src_result = '0;
  logic [N-1:0][TRANS_ID_BITS-1:0] src_id = '0;
  exception_t [N-1:0] src_ex = '0;
  logic wb_valid;
  logic [63:0] wb_result;
  logic [TRANS_ID_BITS-1:0] wb_id;
  exception_t wb_ex;
  logic [31:0] cnt;

  int checks = 0;
  int errors = 0;

  // behavioural model of the writeback slot
  bit m_vld;
  logic [63:0] m_res;
  logic [TRANS_ID_BITS-1:0] m_id;
  exception_t m_ex;
  int m_ptr;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  wb_arbiter #(.NrSrc(N)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .src_valid_i    (src_valid),
    .src_ready_o    (src_ready),
    .src_result_i   (src_result),
    .src_trans_id_i (src_id),
    .src_ex_i       (src_ex),
    .wb_valid_o     (wb_valid),
    .wb_result_o    (wb_result),
    .wb_trans_id_o  (wb_id),
    .wb_ex_o        (wb_ex),
    .wb_ready_i     (wb_ready),
    .conflict_cnt_o (cnt)
  );

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_grant();
    for (int k = 0; k < N; k++)
      if (src_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_vld = 0; m_res = '0; m_id = '0; m_ex = '0; m_ptr = 0; m_cnt = '0;
  endtask

  task automatic set_src(input int i, input logic [63:0] r, input int id);
    src_valid[i] = 1'b1;
    src_result[i] = r;
    src_id[i] = TRANS_ID_BITS'(id);
    src_ex[i] = '{cause: {$urandom, $urandom}, tval: {$urandom, $urandom}, valid: 1'($urandom)};
  endtask

  task automatic refill_all();
    for (int i = 0; i < N; i++)
      if (!src_valid[i]) set_src(i, {$urandom, $urandom}, int'($urandom_range(0, 7)));
  endtask

  // One clock: inputs already set at the preceding negedge. Returns the granted index or -1.
  task automatic step(output int g);
    int j;
    bit take;
    logic [N-1:0] er;
    #1;
    j = model_grant();
    take = (j >= 0) && (!m_vld || wb_ready) && !flush;
    er = '0;
    if (take) er[j] = 1'b1;
    chk("src_ready", src_ready, er);
    g = take ? j : -1;
    @(posedge clk);
`ifdef WB_ARB_CONFLICT_CNT_EN
    if ($countones(src_valid) >= 2 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
    if (flush) m_vld = 0;
    else if (take) begin
      m_vld = 1; m_res = src_result[j]; m_id = src_id[j]; m_ex = src_ex[j];
      m_ptr = (j + 1) % N;
    end else if (wb_ready) m_vld = 0;
    @(negedge clk);
    chk("wb_valid", wb_valid, m_vld);
    if (m_vld) begin
      chk("wb_result", wb_result, m_res);
      chk("wb_trans_id", wb_id, m_id);
      chk("wb_ex", wb_ex, m_ex);
    end
    chk("conflict_cnt", cnt, m_cnt);
    if (take) src_valid[j] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_valid", wb_valid, 1'b0);
    chk("rst_ready", src_ready, '0);
    chk("rst_result", wb_result, 64'h0);
    chk("rst_id", wb_id, '0);
    chk("rst_cnt", cnt, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  int g;
  int rr_exp[5] = '{0, 1, 2, 3, 0};
  logic [63:0] held;

  initial begin
    model_reset();
    src_valid = '0;
    do_reset();

    // single source
    set_src(1, 64'hDEAD, 3);
    wb_ready = 1'b1;
    step(g);
    chk("single_gnt", g, 1);
    chk("single_valid", wb_valid, 1'b1);
    chk("single_result", wb_result, 64'hDEAD);
    chk("single_id", wb_id, 3);

    // all-valid round robin from a fresh pointer
    do_reset();
    wb_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      refill_all();
      step(g);
      chk("rr_order", g, rr_exp[c]);
      chk("rr_valid", wb_valid, 1'b1);
    end

    // backpressure: pointer now 1, slot full
    wb_ready = 1'b0;
    refill_all();
    held = wb_result;
    for (int c = 0; c < 3; c++) begin
      step(g);
      chk("bp_gnt", g, -1);
      chk("bp_hold", wb_result, held);
    end
    wb_ready = 1'b1;
    step(g);
    chk("bp_release", g, 1);

    // flush with a full slot and only source 0 requesting
    src_valid = '0;
    set_src(0, 64'h1234, 5);
    flush = 1'b1;
    step(g);
    chk("flush_gnt", g, -1);
    chk("flush_valid", wb_valid, 1'b0);
    flush = 1'b0;
    refill_all();
    step(g);
    chk("flush_ptr", g, 2);

    // async reset mid-cycle with a full slot
    wb_ready = 1'b0;
    src_valid = '0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", wb_valid, 1'b0);
    chk("async_ready", src_ready, '0);
    chk("async_cnt", cnt, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    wb_ready = 1'b1;
    refill_all();
    step(g);
    chk("async_ptr", g, 0);

`ifdef WB_ARB_CONFLICT_CNT_EN
    do_reset();
    flush = 1'b1;
    src_valid = '0;
    set_src(0, 64'h1, 1); set_src(1, 64'h2, 2);
    for (int c = 0; c < 5; c++) step(g);
    src_valid = 4'b0001;
    for (int c = 0; c < 2; c++) step(g);
    chk("cnt_five", cnt, 32'd5);
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    src_valid = 4'b0011;
    for (int c = 0; c < 3; c++) step(g);
    chk("cnt_sat", cnt, 32'hFFFF_FFFF);
    flush = 1'b0;
`endif

    // randomized traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!src_valid[i] && $urandom_range(0, 1) == 0)
          set_src(i, {$urandom, $urandom}, int'($urandom_range(0, 7)));
      flush = ($urandom_range(0, 9) == 0);
      wb_ready = ($urandom_range(0, 3) != 0);
      step(g);
    end
    flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
